ws2812_led_controller: RTL and testbench
========================================

WS2812_LED_CONTROLLER -- requirements
Module: ws2812_led_controller

Interface
REQ-001 SHALL have parameter clk_mhz, default 27, meaning the system clock frequency in MHz.
REQ-002 SHALL have parameter reset_us, default 80, meaning the minimum latch (line-low) time in microseconds after each frame.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port in_red  input  8  red intensity.
REQ-006 SHALL have port in_green  input  8  green intensity.
REQ-007 SHALL have port in_blue  input  8  blue intensity.
REQ-008 SHALL have port in_valid  input  1  pixel offered.
REQ-009 SHALL have port in_ready  output  1  controller can accept a pixel.
REQ-010 SHALL have port busy  output  1  frame or latch in progress.
REQ-011 SHALL have port dout  output  1  serial line to the on-board WS2812; the board top drives the WS2812 inout from it.

Function
REQ-012 SHALL derive the following integer cycle counts, truncated:
- t_bit = clk_mhz*1250/1000
- t0h = clk_mhz*400/1000
- t1h = clk_mhz*800/1000
- t_latch = clk_mhz*reset_us
REQ-013 SHALL use these values at the default clk_mhz of 27: t_bit=33, t0h=10, t1h=21, t_latch=2160.
REQ-014 SHALL implement states IDLE, HIGH, LOW and LATCH.
REQ-015 SHALL assert in_ready only in IDLE.
REQ-016 SHALL accept a pixel on any cycle where in_valid and in_ready are both 1.
REQ-017 SHALL, on acceptance, capture {green, red, blue} into a 24-bit shift register, clear the bit counter and enter HIGH on the next cycle.
REQ-018 SHALL ignore any changes on the in_* ports after acceptance.
REQ-019 SHALL transmit bits MSB first, in order G7..G0, R7..R0, B7..B0.
REQ-020 SHALL, in HIGH, drive dout=1 for t1h cycles if the current bit is 1 and for t0h cycles if it is 0, then enter LOW.
REQ-021 SHALL, in LOW, drive dout=0 so that high time plus low time equals t_bit exactly, then either:
- shift to the next bit and enter HIGH, or
- after bit 24, enter LATCH.
REQ-022 SHALL, in LATCH, drive dout=0 for t_latch cycles, then enter IDLE.
REQ-023 SHALL register dout, with no combinational path from any input to dout.
REQ-024 SHALL drive busy=1 in every state except IDLE.
REQ-025 SHALL not start a new frame until the current frame's LATCH has fully completed, even when in_valid is held high continuously.
REQ-026 SHALL use a down-counter wide enough for max(t_bit, t_latch), i.e. 12 bits at the defaults, and the counter SHALL never wrap during operation.
REQ-027 SHALL require t0h < t1h < t_bit; an instance violating this is a configuration error.
REQ-028 SHALL drive dout=0 in IDLE.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force dout=0, in_ready=0 and busy=1.
REQ-030 SHALL, while rst_n=0, force state=LATCH, clear the counter and shift register, and load the latch count.
REQ-031 SHALL, after rst_n rises, complete one full LATCH (t_latch cycles) before asserting in_ready, so that a partially sent frame is always terminated.
REQ-032 SHALL, when rst_n is asserted mid-frame, abort the frame immediately; the abort SHALL not be retried.

Configuration
REQ-033 SHALL support the macro WS2812_BRIGHTNESS_LIMIT_EN.
REQ-034 SHALL, when WS2812_BRIGHTNESS_LIMIT_EN is defined, right-shift each captured channel by 2 before loading the shift register (for example, 8'hFF is sent as 8'h3F).
REQ-035 SHALL, when WS2812_BRIGHTNESS_LIMIT_EN is undefined, send the channels unmodified.

Verification
REQ-036 Bench SHALL cover: release rst_n -> in_ready=0 and dout=0 for exactly 2160 cycles, then in_ready=1 and busy=0.
REQ-037 Bench SHALL cover: accept green=8'h80, red=0, blue=0 -> bit 0 is high for 21 cycles and low for 12; bits 1-23 are each high for 10 and low for 23; the frame totals 792 cycles, then LATCH for 2160 cycles.
REQ-038 Bench SHALL cover: in_valid held high with a new value while busy -> no acceptance until IDLE; the first frame still carries its captured value.
REQ-039 Bench SHALL cover: rst_n pulled low at bit 12 of a frame -> dout=0 in the same cycle with no clock edge needed; after release, a full LATCH precedes in_ready=1.
REQ-040 Bench SHALL cover: with WS2812_BRIGHTNESS_LIMIT_EN, accept 8'hFF on all channels -> each byte on the wire is 8'h3F (00111111).
REQ-041 Bench SHALL cover: two back-to-back pixels -> the spacing between the start of frame 1 and the start of frame 2 is at least 792+2160+1 cycles.

Source files
------------

// File: rtl/ws2812_led_controller.sv
`timescale 1ns/1ps
// Purpose : serialises one {G,R,B} pixel per frame onto a WS2812 one-wire line, then holds the latch gap.
// Latency : dout rises on the clock edge that accepts the pixel; a frame is 24*t_bit cycles plus t_latch cycles.
// Backpressure: in_ready is high only in IDLE, so nothing is accepted until the latch gap has fully elapsed.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   in_red/green/blue     8-bit channel intensities, sampled only on acceptance
//   in_valid / in_ready   pixel handshake (accept when both are high)
//   busy                  high in every state other than IDLE (and while in reset)
//   dout                  registered serial line to the WS2812
// Optional feature: define WS2812_BRIGHTNESS_LIMIT_EN to divide every captured channel by 4.

module ws2812_led_controller #(
  parameter int clk_mhz  = 27,
  parameter int reset_us = 80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_red,
  input  logic [7:0] in_green,
  input  logic [7:0] in_blue,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic       dout
);

  localparam int TBit   = clk_mhz * 1250 / 1000;
  localparam int T0h    = clk_mhz * 400 / 1000;
  localparam int T1h    = clk_mhz * 800 / 1000;
  localparam int TLatch = clk_mhz * reset_us;
  localparam int CntMax = (TBit > TLatch) ? TBit : TLatch;
  localparam int CntW   = $clog2(CntMax + 1);

  // The counter is loaded with (duration - 1) and the state changes when it reaches zero,
  // so every phase lasts exactly its nominal number of cycles.
  localparam logic [CntW-1:0] T0hLd   = CntW'(T0h - 1);
  localparam logic [CntW-1:0] T1hLd   = CntW'(T1h - 1);
  localparam logic [CntW-1:0] T0lLd   = CntW'(TBit - T0h - 1);
  localparam logic [CntW-1:0] T1lLd   = CntW'(TBit - T1h - 1);
  localparam logic [CntW-1:0] LatchLd = CntW'(TLatch - 1);

  generate
    if (!(T0h > 0 && T0h < T1h && T1h < TBit && TLatch > 0)) begin : g_cfg_error
      $error("ws2812_led_controller: timing requires 0 < t0h < t1h < t_bit and t_latch > 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [23:0]     shift_q;
  logic [4:0]      bit_q;
  logic            dout_q;
  logic [23:0]     pixel_d;

`ifdef WS2812_BRIGHTNESS_LIMIT_EN
  assign pixel_d = {2'b00, in_green[7:2], 2'b00, in_red[7:2], 2'b00, in_blue[7:2]};
`else
  assign pixel_d = {in_green, in_red, in_blue};
`endif

  // Reset parks the FSM in LATCH with a full latch count so any frame cut short by
  // reset is terminated on the wire before the next pixel can be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LATCH;
      cnt_q   <= LatchLd;
      shift_q <= '0;
      bit_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          dout_q <= 1'b0;
          if (in_valid) begin
            shift_q <= pixel_d;
            bit_q   <= '0;
            state_q <= HIGH;
            dout_q  <= 1'b1;
            cnt_q   <= pixel_d[23] ? T1hLd : T0hLd;
          end
        end
        HIGH: begin
          if (cnt_q == '0) begin
            state_q <= LOW;
            dout_q  <= 1'b0;
            cnt_q   <= shift_q[23] ? T1lLd : T0lLd;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        LOW: begin
          if (cnt_q == '0) begin
            if (bit_q == 5'd23) begin
              state_q <= LATCH;
              cnt_q   <= LatchLd;
            end else begin
              // shift_q[22] becomes the current bit after this shift.
              shift_q <= {shift_q[22:0], 1'b0};
              bit_q   <= bit_q + 1'b1;
              state_q <= HIGH;
              dout_q  <= 1'b1;
              cnt_q   <= shift_q[22] ? T1hLd : T0hLd;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        LATCH: begin
          dout_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= LATCH;
          cnt_q   <= LatchLd;
          dout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign dout     = dout_q;

endmodule

// File: tb/tb_ws2812_led_controller.sv
`timescale 1ns/1ps
module tb_ws2812_led_controller;

  localparam int CLK_MHZ  = 27;
  localparam int RESET_US = 80;
  localparam int T_BIT    = CLK_MHZ * 1250 / 1000;
  localparam int T0H      = CLK_MHZ * 400 / 1000;
  localparam int T1H      = CLK_MHZ * 800 / 1000;
  localparam int T_LATCH  = CLK_MHZ * RESET_US;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_red = '0;
  logic [7:0] in_green = '0;
  logic [7:0] in_blue = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       busy;
  logic       dout;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  int hi_w[24];
  int lo_w[24];

  ws2812_led_controller #(.clk_mhz(CLK_MHZ), .reset_us(RESET_US)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .in_valid(in_valid), .in_ready(in_ready), .busy(busy), .dout(dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Word as it should appear on the wire, in transmission order.
  function automatic logic [23:0] wire_word(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
`ifdef WS2812_BRIGHTNESS_LIMIT_EN
    return {g >> 2, r >> 2, b >> 2};
`else
    return {g, r, b};
`endif
  endfunction

  // Reference model: a queue holding the expected dout level for each upcoming cycle.
  // A non-empty queue means the controller is busy; empty means idle and ready.
  bit exp_q[$];

  function automatic void push_frame(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) begin
      int h;
      h = w[i] ? T1H : T0H;
      for (int k = 0; k < h; k++) exp_q.push_back(1'b1);
      for (int k = 0; k < T_BIT - h; k++) exp_q.push_back(1'b0);
    end
    for (int k = 0; k < T_LATCH; k++) exp_q.push_back(1'b0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int k = 0; k < T_LATCH; k++) exp_q.push_back(1'b0);
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else if (in_valid) begin
      push_frame(wire_word(in_green, in_red, in_blue));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_busy;
      logic e_dout;
      e_busy = (exp_q.size() != 0);
      e_dout = e_busy ? exp_q[0] : 1'b0;
      nvec++;
      if (dout !== e_dout || busy !== e_busy || in_ready !== !e_busy) begin
        nerr++;
        $display("FAIL cycle_compare cyc=%0d dout=%b want %b busy=%b want %b in_ready=%b want %b",
                 cyc, dout, e_dout, busy, e_busy, in_ready, !e_busy);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Counts cycles (sampled on negedges) until in_ready rises.
  task automatic count_until_ready(output int n);
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Decodes one frame from dout; tail = low cycles after the last bit's high until in_ready.
  task automatic capture(output logic [23:0] val, output int start_c, output int tail);
    int n;
    val = '0;
    start_c = 0;
    tail = 0;
    n = 0;
    @(negedge clk);
    while (dout !== 1'b1 && n < 6000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 6000) begin
      chk("frame_start_timeout", 32'(n), 32'd0);
      return;
    end
    start_c = cyc;
    for (int i = 0; i < 24; i++) begin
      int h;
      int l;
      h = 0;
      while (dout === 1'b1 && h < 100) begin
        h++;
        @(negedge clk);
      end
      hi_w[i] = h;
      val[23 - i] = (h > (T0H + T1H) / 2);
      l = 0;
      if (i < 23) begin
        while (dout === 1'b0 && l < 100) begin
          l++;
          @(negedge clk);
        end
        lo_w[i] = l;
      end else begin
        while (in_ready !== 1'b1 && l < 5000) begin
          l++;
          @(negedge clk);
        end
        tail = l;
      end
    end
  endtask

  initial begin
    logic [23:0] v1;
    logic [23:0] v2;
    logic [7:0]  ag, ar, ab;
    int s1, s2, tail, n, total;

    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #2;
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_dout", 32'(dout), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    count_until_ready(n);
    chk("post_reset_latch_len", 32'(n), 32'd2160);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_dout", 32'(dout), 32'd0);

    // Single green=0x80 pixel; inputs scrambled right after acceptance.
    in_green = 8'h80; in_red = 8'h00; in_blue = 8'h00; in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_green = 8'($urandom); in_red = 8'($urandom); in_blue = 8'($urandom);
    capture(v1, s1, tail);
`ifdef WS2812_BRIGHTNESS_LIMIT_EN
    chk("g80_word", 32'(v1), 32'h200000);
    chk("g80_bit0_hi", 32'(hi_w[0]), 32'd10);
    chk("g80_bit2_hi", 32'(hi_w[2]), 32'd21);
    chk("g80_bit2_lo", 32'(lo_w[2]), 32'd12);
`else
    chk("g80_word", 32'(v1), 32'h800000);
    chk("g80_bit0_hi", 32'(hi_w[0]), 32'd21);
    chk("g80_bit0_lo", 32'(lo_w[0]), 32'd12);
    chk("g80_bit1_hi", 32'(hi_w[1]), 32'd10);
    chk("g80_bit1_lo", 32'(lo_w[1]), 32'd23);
`endif
    chk("g80_bit23_hi", 32'(hi_w[23]), 32'd10);
    chk("g80_tail", 32'(tail), 32'd2183);
    total = hi_w[23] + tail - T_LATCH;
    for (int i = 0; i < 23; i++) total += hi_w[i] + lo_w[i];
    chk("g80_frame_len", 32'(total), 32'd792);

    // Back-to-back: valid held high, data changed while busy.
    ag = 8'($urandom); ar = 8'($urandom); ab = 8'($urandom);
    in_green = ag; in_red = ar; in_blue = ab; in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_green = ~ag; in_red = ~ar; in_blue = ~ab;
    capture(v1, s1, tail);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    capture(v2, s2, tail);
    chk("b2b_first_word", 32'(v1), 32'(wire_word(ag, ar, ab)));
    chk("b2b_second_word", 32'(v2), 32'(wire_word(~ag, ~ar, ~ab)));
    chk("b2b_spacing_ok", 32'((s2 - s1) >= 2953), 32'd1);

    // All channels full scale.
    in_green = 8'hFF; in_red = 8'hFF; in_blue = 8'hFF; in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    capture(v1, s1, tail);
`ifdef WS2812_BRIGHTNESS_LIMIT_EN
    chk("ff_word", 32'(v1), 32'h3F3F3F);
    chk("ff_bit0_hi", 32'(hi_w[0]), 32'd10);
    chk("ff_bit2_hi", 32'(hi_w[2]), 32'd21);
`else
    chk("ff_word", 32'(v1), 32'hFFFFFF);
    chk("ff_bit0_hi", 32'(hi_w[0]), 32'd21);
`endif
    chk("ff_tail", 32'(tail), 32'(T_BIT - hi_w[23] + T_LATCH));

    // Random traffic, checked cycle by cycle against the model.
    for (int k = 0; k < 9000; k++) begin
      @(posedge clk);
      #2;
      in_valid = ($urandom_range(0, 3) == 0);
      in_green = 8'($urandom); in_red = 8'($urandom); in_blue = 8'($urandom);
    end
    in_valid = 1'b0;
    count_until_ready(n);
    chk("random_drain_ready", 32'(in_ready), 32'd1);

    // Reset asserted in the middle of bit 12.
    in_green = 8'($urandom); in_red = 8'($urandom); in_blue = 8'($urandom); in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    repeat (12 * T_BIT + 5) @(posedge clk);
    #3;
    chk("abort_pre_dout", 32'(dout), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_dout", 32'(dout), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    count_until_ready(n);
    chk("abort_latch_len", 32'(n), 32'd2160);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
